// File: rtl/vga_sync_if.sv
// Video timing bundle from the sync generator to its consumers
// (text RAM, font ROM, interrupt logic).
interface vga_sync_if;
    logic       h_sync;
    logic       v_sync;
    logic       active;
    logic       blanking_start;
    logic [9:0] x;
    logic [9:0] y;

    modport master (
        output h_sync, v_sync, active, blanking_start, x, y
    );

    modport slave (
        input  h_sync, v_sync, active, blanking_start, x, y
    );
endinterface

// File: rtl/vga_sync_gen.sv
// Pixel/line counter with registered sync, active-video and start-of-blanking flags.
// The flags are decoded from the next-state counters, so they line up with the registered x/y.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_sync_if.master vid_o
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    // Boundaries are 11 bits wide because a region end may equal 1024.
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        h_sync_q, h_sync_d;
    logic        v_sync_q, v_sync_d;
    logic        active_q, active_d;
    logic        blank_start_q, blank_start_d;
    logic        h_wrap;
    logic [10:0] x_ext;
    logic [10:0] y_ext;

    always_comb begin
        h_wrap = (x_q == H_LAST);
        x_d    = h_wrap ? 10'd0 : x_q + 10'd1;
        y_d    = y_q;
        if (h_wrap) begin
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end

        x_ext = {1'b0, x_d};
        y_ext = {1'b0, y_d};

        active_d      = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
        h_sync_d      = ((x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        v_sync_d      = ((y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        blank_start_d = (x_d == 10'd0) && (y_ext == V_ACT_END);
    end

    // Reset parks the counters on the last pixel so the first edge lands on (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            h_sync_q      <= ~SYNC_POL;
            v_sync_q      <= ~SYNC_POL;
            active_q      <= 1'b0;
            blank_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            active_q      <= active_d;
            blank_start_q <= blank_start_d;
        end
    end

    assign vid_o.x              = x_q;
    assign vid_o.y              = y_q;
    assign vid_o.h_sync         = h_sync_q;
    assign vid_o.v_sync         = v_sync_q;
    assign vid_o.active         = active_q;
    assign vid_o.blanking_start = blank_start_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 800x525 timing and a small 14x7 active-high instance,
// checked every cycle against a position-from-edge-count model plus directed literals.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic rst_n_a = 1'b1;
    logic rst_n_b = 1'b1;
    bit   chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    vga_sync_if vid_a ();
    vga_sync_if vid_b ();

    vga_sync_gen u_dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .vid_o (vid_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .vid_o (vid_b)
    );

    always #5 clk = ~clk;

    // Rising edges seen with reset released; 0 means still showing reset values.
    int n_a = 0;
    int n_b = 0;
    always @(posedge clk or negedge rst_n_a) begin
        if (!rst_n_a) n_a <= 0;
        else          n_a <= n_a + 1;
    end
    always @(posedge clk or negedge rst_n_b) begin
        if (!rst_n_b) n_b <= 0;
        else          n_b <= n_b + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input bit verbose);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else if (verbose) begin
            $display("check %s ok: %0d (t=%0t)", name, act, $time);
        end
    endtask

    // Position is simply the number of edges since release, folded by the line and frame lengths.
    task automatic model(input int n, input int ha, input int hf, input int hs, input int hb,
                         input int va, input int vf, input int vs, input int vb, input bit pol,
                         output int ex, output int ey, output bit ehs, output bit evs,
                         output bit eact, output bit eblk);
        int ht, vt, p;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (n == 0) begin
            ex = ht - 1; ey = vt - 1;
            ehs = !pol; evs = !pol; eact = 1'b0; eblk = 1'b0;
        end else begin
            p    = n - 1;
            ex   = p % ht;
            ey   = (p / ht) % vt;
            eact = (ex < ha) && (ey < va);
            ehs  = (ex >= ha + hf && ex < ha + hf + hs) ? pol : !pol;
            evs  = (ey >= va + vf && ey < va + vf + vs) ? pol : !pol;
            eblk = (ex == 0) && (ey == va);
        end
    endtask

    always @(negedge clk) begin
        int ex, ey;
        bit ehs, evs, eact, eblk;
        if (chk_en) begin
            model(n_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, ex, ey, ehs, evs, eact, eblk);
            chk("a.x", 32'(vid_a.x), ex, 1'b0);
            chk("a.y", 32'(vid_a.y), ey, 1'b0);
            chk("a.h_sync", 32'(vid_a.h_sync), 32'(ehs), 1'b0);
            chk("a.v_sync", 32'(vid_a.v_sync), 32'(evs), 1'b0);
            chk("a.active", 32'(vid_a.active), 32'(eact), 1'b0);
            chk("a.blank", 32'(vid_a.blanking_start), 32'(eblk), 1'b0);
            model(n_b, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, ex, ey, ehs, evs, eact, eblk);
            chk("b.x", 32'(vid_b.x), ex, 1'b0);
            chk("b.y", 32'(vid_b.y), ey, 1'b0);
            chk("b.h_sync", 32'(vid_b.h_sync), 32'(ehs), 1'b0);
            chk("b.v_sync", 32'(vid_b.v_sync), 32'(evs), 1'b0);
            chk("b.active", 32'(vid_b.active), 32'(eact), 1'b0);
            chk("b.blank", 32'(vid_b.blanking_start), 32'(eblk), 1'b0);
        end
    end

    task automatic lit_a(input string tag, input int x, input int y, input bit hs, input bit vs,
                         input bit act, input bit blk);
        chk({tag, " a.x"}, 32'(vid_a.x), x, 1'b1);
        chk({tag, " a.y"}, 32'(vid_a.y), y, 1'b1);
        chk({tag, " a.h_sync"}, 32'(vid_a.h_sync), 32'(hs), 1'b1);
        chk({tag, " a.v_sync"}, 32'(vid_a.v_sync), 32'(vs), 1'b1);
        chk({tag, " a.active"}, 32'(vid_a.active), 32'(act), 1'b1);
        chk({tag, " a.blank"}, 32'(vid_a.blanking_start), 32'(blk), 1'b1);
    endtask

    task automatic lit_b(input string tag, input int x, input int y, input bit hs, input bit vs,
                         input bit act, input bit blk);
        chk({tag, " b.x"}, 32'(vid_b.x), x, 1'b1);
        chk({tag, " b.y"}, 32'(vid_b.y), y, 1'b1);
        chk({tag, " b.h_sync"}, 32'(vid_b.h_sync), 32'(hs), 1'b1);
        chk({tag, " b.v_sync"}, 32'(vid_b.v_sync), 32'(vs), 1'b1);
        chk({tag, " b.active"}, 32'(vid_b.active), 32'(act), 1'b1);
        chk({tag, " b.blank"}, 32'(vid_b.blanking_start), 32'(blk), 1'b1);
    endtask

    int act_cnt, hs_cnt, hs_first, hs_last;
    int vs_cnt, hsb_cnt, blk_cnt, blk_act, org_cnt, org_last, org_bad, blk_last, blk_bad;

    initial begin
        #1 rst_n_a = 1'b0; rst_n_b = 1'b0;
        #1 chk_en = 1'b1;
        #1;
        lit_a("reset", 799, 524, 1'b1, 1'b1, 1'b0, 1'b0);
        lit_b("reset", 13, 6, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2 rst_n_a = 1'b1; rst_n_b = 1'b1;
        @(posedge clk); #1;
        lit_a("first", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        lit_b("first", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        // One full default line, sampled from x=0.
        act_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 800; i++) begin
            if (vid_a.active === 1'b1) act_cnt++;
            if (vid_a.h_sync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(vid_a.x);
                hs_last = int'(vid_a.x);
            end
            @(posedge clk); #1;
        end
        chk("line active clks", act_cnt, 640, 1'b1);
        chk("line hsync clks", hs_cnt, 96, 1'b1);
        chk("line hsync first x", hs_first, 656, 1'b1);
        chk("line hsync last x", hs_last, 751, 1'b1);
        lit_a("line wrap", 0, 1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Mid-frame reset on the default instance.
        repeat (1120) @(posedge clk);
        #1;
        lit_a("pre-reset", 320, 2, 1'b1, 1'b1, 1'b1, 1'b0);
        rst_n_a = 1'b0;
        #1;
        lit_a("mid reset", 799, 524, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n_a = 1'b1;
        @(posedge clk); #1;
        lit_a("restart", 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);

        // Exactly three small frames, any starting phase.
        vs_cnt = 0; hsb_cnt = 0; act_cnt = 0; blk_cnt = 0; blk_act = 0;
        org_cnt = 0; org_last = -1; org_bad = 0; blk_last = -1; blk_bad = 0;
        for (int i = 0; i < 294; i++) begin
            if (vid_b.v_sync === 1'b1) vs_cnt++;
            if (vid_b.h_sync === 1'b1) hsb_cnt++;
            if (vid_b.active === 1'b1) act_cnt++;
            if (vid_b.blanking_start === 1'b1) begin
                blk_cnt++;
                if (vid_b.active === 1'b1) blk_act++;
                if (blk_last >= 0 && i - blk_last != 98) blk_bad++;
                blk_last = i;
            end
            if (vid_b.x === 10'd0 && vid_b.y === 10'd0) begin
                org_cnt++;
                if (org_last >= 0 && i - org_last != 98) org_bad++;
                org_last = i;
            end
            @(posedge clk); #1;
        end
        chk("small vsync clks", vs_cnt, 42, 1'b1);
        chk("small hsync clks", hsb_cnt, 42, 1'b1);
        chk("small active clks", act_cnt, 96, 1'b1);
        chk("small blank pulses", blk_cnt, 3, 1'b1);
        chk("small blank with active", blk_act, 0, 1'b1);
        chk("small blank spacing errs", blk_bad, 0, 1'b1);
        chk("small origin count", org_cnt, 3, 1'b1);
        chk("small frame period errs", org_bad, 0, 1'b1);

        // Mid-frame reset on the small instance.
        repeat (37) @(posedge clk);
        #2 rst_n_b = 1'b0;
        #1;
        lit_b("mid reset", 13, 6, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n_b = 1'b1;
        @(posedge clk); #1;
        lit_b("restart", 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (200) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
